// File: rtl/fdiv_share_arbiter.sv
// fdiv_share_arbiter: shares one iterative FP divider between two requesters.
// Round-robin grant, one operation in flight, and a tagged shared response channel.
// Optional watchdog on the divider wait: define FDIV_TIMEOUT_EN to enable it.
module fdiv_share_arbiter #(
  parameter int XLEN        = 32,
  parameter int TAG_W       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [2*XLEN-1:0]    req_a,
  input  logic [2*XLEN-1:0]    req_b,
  input  logic [2*TAG_W-1:0]   req_tag,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [TAG_W-1:0]     rsp_tag,
  output logic [XLEN-1:0]      rsp_result,
  output logic                 rsp_dz,
  output logic                 rsp_timeout,
  output logic                 div_valid,
  output logic [XLEN-1:0]      div_dividend,
  output logic [XLEN-1:0]      div_divisor,
  input  logic                 div_ready,
  input  logic [XLEN-1:0]      div_result,
  input  logic                 div_dz,
  output logic                 busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t             state_q;
  logic               last_grant_q;
  logic [XLEN-1:0]    op_a_q, op_b_q;
  logic [TAG_W-1:0]   tag_q;
  logic               id_q;
  logic [XLEN-1:0]    rsp_result_q;
  logic               rsp_dz_q;
  logic               rsp_valid_q;
  logic               div_valid_q;
  logic               busy_q;

  logic [XLEN-1:0]    lane_a   [2];
  logic [XLEN-1:0]    lane_b   [2];
  logic [TAG_W-1:0]   lane_tag [2];
  logic               grant_id;
  logic               grant_ok;

  // Unpack the two requester lanes from the flat port vectors.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    assign lane_a[gi]   = req_a[gi*XLEN +: XLEN];
    assign lane_b[gi]   = req_b[gi*XLEN +: XLEN];
    assign lane_tag[gi] = req_tag[gi*TAG_W +: TAG_W];
  end

  // Round-robin choice: a lone valid lane wins; on a tie the lane not served last wins.
  always_comb begin
    grant_ok = |req_valid;
    grant_id = 1'b0;
    unique case (req_valid)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_grant_q;
      default: grant_id = 1'b0;
    endcase
    req_ready = 2'b00;
    if (state_q == S_IDLE && grant_ok) begin
      req_ready = grant_id ? 2'b10 : 2'b01;
    end
  end

`ifdef FDIV_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] wait_cnt_q;
  logic             rsp_timeout_q;
  assign rsp_timeout = rsp_timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYC;
  assign rsp_timeout        = 1'b0;
`endif

  // Operation sequencer: accept, launch, wait for the divider, hold the response.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      op_a_q       <= '0;
      op_b_q       <= '0;
      tag_q        <= '0;
      id_q         <= 1'b0;
      rsp_result_q <= '0;
      rsp_dz_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      div_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef FDIV_TIMEOUT_EN
      wait_cnt_q    <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      div_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (grant_ok) begin
            op_a_q       <= lane_a[grant_id];
            op_b_q       <= lane_b[grant_id];
            tag_q        <= lane_tag[grant_id];
            id_q         <= grant_id;
            last_grant_q <= grant_id;
            div_valid_q  <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // A done pulse here cannot belong to this op, so it is ignored.
          state_q <= S_WAIT;
`ifdef FDIV_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
        end
        S_WAIT: begin
          if (div_ready) begin
            rsp_result_q <= div_result;
            rsp_dz_q     <= div_dz;
            rsp_valid_q  <= 1'b1;
            state_q      <= S_RESP;
`ifdef FDIV_TIMEOUT_EN
            rsp_timeout_q <= 1'b0;
          end else if (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            // Divider never answered: return a quiet NaN flagged as a timeout.
            rsp_result_q  <= XLEN'(32'h7FC0_0000);
            rsp_dz_q      <= 1'b0;
            rsp_timeout_q <= 1'b1;
            rsp_valid_q   <= 1'b1;
            state_q       <= S_RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
`endif
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = id_q;
  assign rsp_tag      = tag_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_dz       = rsp_dz_q;
  assign div_valid    = div_valid_q;
  assign div_dividend = op_a_q;
  assign div_divisor  = op_b_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_fdiv_share_arbiter.sv
// Directed testbench for fdiv_share_arbiter with a behavioural divider stub.
// The stub returns hand-computed quotients for the operand pairs used below.
module tb_fdiv_share_arbiter;

  logic        CLK = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a, req_b;
  logic [7:0]  req_tag;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [3:0]  rsp_tag;
  logic [31:0] rsp_result;
  logic        rsp_dz, rsp_timeout;
  logic        div_valid;
  logic [31:0] div_dividend, div_divisor;
  logic        div_ready;
  logic [31:0] div_result;
  logic        div_dz;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  fdiv_share_arbiter #(.XLEN(32), .TAG_W(4), .TIMEOUT_CYC(8)) dut (
    .CLK(CLK), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_tag(rsp_tag), .rsp_result(rsp_result), .rsp_dz(rsp_dz),
    .rsp_timeout(rsp_timeout),
    .div_valid(div_valid), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_ready(div_ready), .div_result(div_result), .div_dz(div_dz),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Hand-computed IEEE-754 single quotients for the vectors used here.
  function automatic logic [31:0] quot(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] key;
    key = {a, b};
    case (key)
      64'h42B6B000_3E140000: quot = 32'h441E0000; // 91.34375 / 0.14453125 = 632
      64'h41600000_40000000: quot = 32'h40E00000; // 14 / 2 = 7
      64'h40400000_40000000: quot = 32'h3FC00000; // 3 / 2 = 1.5
      64'h41940000_40000000: quot = 32'h41140000; // 18.5 / 2 = 9.25
      64'h41B00000_00000000: quot = 32'h7F800000; // 22 / 0 = +inf
      64'h41B00000_40E00000: quot = 32'h40492492; // 22 / 7
      default:               quot = 32'hDEADBEEF;
    endcase
  endfunction

  // Divider stub: latches operands on the launch pulse, answers div_lat cycles later.
  int          div_lat = 3;
  bit          stub_en = 1'b1;
  logic        stub_ready;
  logic        man_ready = 1'b0;
  logic [31:0] sa, sb;
  int          scnt;

  always @(posedge CLK) begin
    stub_ready <= 1'b0;
    if (rst) begin
      scnt       <= 0;
      div_result <= 32'h0;
      div_dz     <= 1'b0;
    end else if (div_valid) begin
      sa   <= div_dividend;
      sb   <= div_divisor;
      scnt <= div_lat;
    end else if (scnt > 0) begin
      scnt <= scnt - 1;
      if (scnt == 1 && stub_en) begin
        stub_ready <= 1'b1;
        div_result <= quot(sa, sb);
        div_dz     <= (sb[30:0] == 31'h0);
      end
    end
  end

  assign div_ready = stub_ready | man_ready;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset;
    rst       = 1'b1;
    req_valid = 2'b00;
    req_a     = 64'h0;
    req_b     = 64'h0;
    req_tag   = 8'h0;
    rsp_ready = 1'b0;
    man_ready = 1'b0;
    stub_en   = 1'b1;
    div_lat   = 3;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rsp_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick;
    end
  endtask

  task automatic pulse_div_ready;
    man_ready = 1'b1;
    tick;
    man_ready = 1'b0;
  endtask

  task automatic test_reset;
    apply_reset;
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); else n_pass++;
    n_checks++; if (div_valid !== 1'b0) $display("FAIL reset_div_valid got=%b exp=0", div_valid); else n_pass++;
    n_checks++; if (req_ready !== 2'b00) $display("FAIL reset_req_ready got=%b exp=00", req_ready); else n_pass++;
    n_checks++; if (rsp_result !== 32'h0 || rsp_timeout !== 1'b0) $display("FAIL reset_rsp_fields got=%h/%b exp=0/0", rsp_result, rsp_timeout); else n_pass++;
  endtask

  task automatic test_single_lane0;
    bit ok;
    req_valid = 2'b01;
    req_a     = {32'h0, 32'h42B6B000};
    req_b     = {32'h0, 32'h3E140000};
    req_tag   = 8'h05;
    #1;
    n_checks++; if (req_ready !== 2'b01) $display("FAIL t1_req_ready got=%b exp=01", req_ready); else n_pass++;
    tick;
    req_valid = 2'b00;
    n_checks++; if (div_valid !== 1'b1) $display("FAIL t1_div_valid_launch got=%b exp=1", div_valid); else n_pass++;
    n_checks++; if (div_dividend !== 32'h42B6B000 || div_divisor !== 32'h3E140000) $display("FAIL t1_operands got=%h/%h exp=42b6b000/3e140000", div_dividend, div_divisor); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL t1_busy got=%b exp=1", busy); else n_pass++;
    tick;
    n_checks++; if (div_valid !== 1'b0) $display("FAIL t1_div_valid_single got=%b exp=0", div_valid); else n_pass++;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (div_ready === 1'b1) begin ok = 1'b1; break; end
      tick;
    end
    n_checks++; if (!ok || rsp_valid !== 1'b0) $display("FAIL t1_div_ready_seen got=%b/%b exp=1/0", ok, rsp_valid); else n_pass++;
    tick;
    n_checks++; if (rsp_valid !== 1'b1) $display("FAIL t1_rsp_latency got=%b exp=1", rsp_valid); else n_pass++;
    $display("txn t1 id=%0d tag=%h result=%h dz=%b", rsp_id, rsp_tag, rsp_result, rsp_dz);
    n_checks++; if (rsp_id !== 1'b0 || rsp_tag !== 4'h5) $display("FAIL t1_id_tag got=%b/%h exp=0/5", rsp_id, rsp_tag); else n_pass++;
    n_checks++; if (rsp_result !== 32'h441E0000 || rsp_dz !== 1'b0) $display("FAIL t1_result got=%h/%b exp=441e0000/0", rsp_result, rsp_dz); else n_pass++;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL t1_release got=%b/%b exp=0/0", rsp_valid, busy); else n_pass++;
  endtask

  task automatic test_round_robin;
    bit ok;
    logic        exp_id;
    logic [31:0] exp_res;
    logic [3:0]  exp_tag;
    apply_reset;
    req_valid = 2'b11;
    req_a     = {32'h40400000, 32'h41600000};
    req_b     = {32'h40000000, 32'h40000000};
    req_tag   = {4'h3, 4'hA};
    rsp_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 2'b01) $display("FAIL t2_first_grant got=%b exp=01", req_ready); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      exp_id  = (k % 2 == 1);
      exp_res = exp_id ? 32'h3FC00000 : 32'h40E00000;
      exp_tag = exp_id ? 4'h3 : 4'hA;
      wait_rsp(ok);
      n_checks++; if (!ok) $display("FAIL t2_rsp_timeout op=%0d got=none exp=response", k); else n_pass++;
      $display("txn t2 op=%0d id=%0d tag=%h result=%h", k, rsp_id, rsp_tag, rsp_result);
      n_checks++; if (rsp_id !== exp_id || rsp_tag !== exp_tag || rsp_result !== exp_res) $display("FAIL t2_op%0d got=%b/%h/%h exp=%b/%h/%h", k, rsp_id, rsp_tag, rsp_result, exp_id, exp_tag, exp_res); else n_pass++;
      tick;
    end
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    tick;
  endtask

  task automatic test_backpressure;
    bit ok;
    bit bad;
    req_valid = 2'b01;
    req_a     = {32'h40400000, 32'h41940000};
    req_b     = {32'h40000000, 32'h40000000};
    req_tag   = {4'h1, 4'h7};
    rsp_ready = 1'b0;
    #1;
    n_checks++; if (req_ready !== 2'b01) $display("FAIL t3_req_ready got=%b exp=01", req_ready); else n_pass++;
    tick;
    req_valid = 2'b11;
    wait_rsp(ok);
    n_checks++; if (!ok || rsp_result !== 32'h41140000 || rsp_tag !== 4'h7) $display("FAIL t3_result got=%b/%h/%h exp=1/41140000/7", ok, rsp_result, rsp_tag); else n_pass++;
    $display("txn t3 id=%0d tag=%h result=%h", rsp_id, rsp_tag, rsp_result);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (rsp_valid !== 1'b1 || rsp_result !== 32'h41140000 || req_ready !== 2'b00 || div_valid !== 1'b0) bad = 1'b1;
    end
    n_checks++; if (bad) $display("FAIL t3_hold got=unstable exp=stable_rsp_no_grant"); else n_pass++;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL t3_release got=%b exp=0", rsp_valid); else n_pass++;
  endtask

  task automatic test_div_by_zero;
    bit ok;
    req_valid = 2'b10;
    req_a     = {32'h41B00000, 32'h0};
    req_b     = {32'h00000000, 32'h0};
    req_tag   = {4'h9, 4'h0};
    #1;
    n_checks++; if (req_ready !== 2'b10) $display("FAIL t4_req_ready got=%b exp=10", req_ready); else n_pass++;
    tick;
    req_valid = 2'b00;
    wait_rsp(ok);
    $display("txn t4a id=%0d tag=%h result=%h dz=%b", rsp_id, rsp_tag, rsp_result, rsp_dz);
    n_checks++; if (!ok || rsp_dz !== 1'b1 || rsp_id !== 1'b1 || rsp_tag !== 4'h9) $display("FAIL t4_dz got=%b/%b/%b/%h exp=1/1/1/9", ok, rsp_dz, rsp_id, rsp_tag); else n_pass++;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    req_valid = 2'b10;
    req_b     = {32'h40E00000, 32'h0};
    tick;
    req_valid = 2'b00;
    wait_rsp(ok);
    $display("txn t4b id=%0d tag=%h result=%h dz=%b", rsp_id, rsp_tag, rsp_result, rsp_dz);
    n_checks++; if (!ok || rsp_result !== 32'h40492492 || rsp_dz !== 1'b0 || rsp_id !== 1'b1) $display("FAIL t4_nonzero got=%b/%h/%b/%b exp=1/40492492/0/1", ok, rsp_result, rsp_dz, rsp_id); else n_pass++;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
  endtask

  task automatic test_idle_div_ready;
    pulse_div_ready;
    tick;
    n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL idle_div_ready got=%b/%b exp=0/0", rsp_valid, busy); else n_pass++;
  endtask

  task automatic test_reset_mid_op;
    bit ok;
    bit bad;
    div_lat   = 20;
    req_valid = 2'b01;
    req_a     = {32'h0, 32'h41600000};
    req_b     = {32'h0, 32'h40000000};
    req_tag   = 8'h04;
    tick;
    req_valid = 2'b00;
    tick;
    tick;
    tick;
    n_checks++; if (busy !== 1'b1) $display("FAIL t5_busy_in_wait got=%b exp=1", busy); else n_pass++;
    rst = 1'b1;
    tick;
    n_checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) $display("FAIL t5_reset_edge got=%b/%b exp=0/0", busy, rsp_valid); else n_pass++;
    tick;
    rst     = 1'b0;
    div_lat = 3;
    bad     = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    n_checks++; if (bad) $display("FAIL t5_no_stale_rsp got=response exp=none"); else n_pass++;
    req_valid = 2'b01;
    tick;
    req_valid = 2'b00;
    wait_rsp(ok);
    $display("txn t5 id=%0d tag=%h result=%h", rsp_id, rsp_tag, rsp_result);
    n_checks++; if (!ok || rsp_result !== 32'h40E00000 || rsp_id !== 1'b0 || rsp_tag !== 4'h4) $display("FAIL t5_after_reset got=%b/%h/%b/%h exp=1/40e00000/0/4", ok, rsp_result, rsp_id, rsp_tag); else n_pass++;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
  endtask

`ifdef FDIV_TIMEOUT_EN
  task automatic test_timeout;
    bit bad;
    stub_en   = 1'b0;
    req_valid = 2'b01;
    req_a     = {32'h0, 32'h40400000};
    req_b     = {32'h0, 32'h40000000};
    req_tag   = 8'h02;
    tick;
    req_valid = 2'b00;
    n_checks++; if (div_valid !== 1'b1) $display("FAIL t6_launch got=%b exp=1", div_valid); else n_pass++;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (rsp_valid !== 1'b0) bad = 1'b1;
    end
    n_checks++; if (bad) $display("FAIL t6_early_abort got=response exp=none_for_8_cycles"); else n_pass++;
    tick;
    $display("txn t6 id=%0d result=%h timeout=%b", rsp_id, rsp_result, rsp_timeout);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b1 || rsp_result !== 32'h7FC00000 || rsp_dz !== 1'b0) $display("FAIL t6_abort got=%b/%b/%h/%b exp=1/1/7fc00000/0", rsp_valid, rsp_timeout, rsp_result, rsp_dz); else n_pass++;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    pulse_div_ready;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    n_checks++; if (bad) $display("FAIL t6_late_ready got=response exp=none"); else n_pass++;
    stub_en = 1'b1;
  endtask
`else
  task automatic test_no_timeout;
    bit bad;
    stub_en   = 1'b0;
    req_valid = 2'b01;
    req_a     = {32'h0, 32'h40400000};
    req_b     = {32'h0, 32'h40000000};
    req_tag   = 8'h02;
    tick;
    req_valid = 2'b00;
    bad = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick;
      if (rsp_valid !== 1'b0 || busy !== 1'b1) bad = 1'b1;
    end
    n_checks++; if (bad) $display("FAIL t6_wait_holds got=left_wait exp=stay_in_wait"); else n_pass++;
    pulse_div_ready;
    $display("txn t6 id=%0d tag=%h timeout=%b", rsp_id, rsp_tag, rsp_timeout);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b0 || rsp_tag !== 4'h2) $display("FAIL t6_late_done got=%b/%b/%h exp=1/0/2", rsp_valid, rsp_timeout, rsp_tag); else n_pass++;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    stub_en = 1'b1;
  endtask
`endif

  initial begin
    rst       = 1'b1;
    req_valid = 2'b00;
    req_a     = 64'h0;
    req_b     = 64'h0;
    req_tag   = 8'h0;
    rsp_ready = 1'b0;
    test_reset;
    test_single_lane0;
    test_round_robin;
    test_backpressure;
    test_div_by_zero;
    test_idle_div_ready;
    test_reset_mid_op;
`ifdef FDIV_TIMEOUT_EN
    test_timeout;
`else
    test_no_timeout;
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
